// File: rtl/wb_pkg.sv
// Shared types and width helpers for the Wishbone width converter.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } wb_bridge_state_e;

  localparam int WB_GRANULARITY = 8;

  // Index width for n items; never below one bit so ports stay legal at n == 1.
  function automatic int wb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Address offset bits covered by n byte lanes (zero for a single lane).
  function automatic int wb_off_width(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

endpackage

// File: rtl/wb_lane_seek.sv
// Finds the lowest beat index >= start whose byte-select slice is non-zero.
module wb_lane_seek
  import wb_pkg::*;
#(
  parameter int WSEL  = 4,
  parameter int NSEL  = 1,
  parameter int RATIO = 4,
  parameter int BW    = wb_idx_width(RATIO)
) (
  input  logic [WSEL-1:0] sel,
  input  logic [BW:0]     start,
  output logic [BW-1:0]   beat,
  output logic            found
);

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    beat  = '0;
    found = 1'b0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      if ((k >= int'(start)) && (|sel[k*NSEL +: NSEL])) begin
        found = 1'b1;
        beat  = BW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_downsizer.sv
// Wishbone classic wide-to-narrow bridge: splits each access into narrow beats,
// skipping empty select slices, with error propagation and upstream abort.
module wb_downsizer
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int WIDE_WIDTH   = 32,
  parameter int NARROW_WIDTH = 8,
  parameter int GRANULARITY  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [ADDR_WIDTH-1:0]       wbs_adr_i,
  input  logic [WIDE_WIDTH-1:0]       wbs_dat_i,
  output logic [WIDE_WIDTH-1:0]       wbs_dat_o,
  input  logic                        wbs_we_i,
  input  logic [WIDE_WIDTH/8-1:0]     wbs_sel_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  output logic                        wbs_ack_o,
  output logic                        wbs_err_o,
  output logic [ADDR_WIDTH-1:0]       wbm_adr_o,
  output logic [NARROW_WIDTH-1:0]     wbm_dat_o,
  input  logic [NARROW_WIDTH-1:0]     wbm_dat_i,
  output logic                        wbm_we_o,
  output logic [NARROW_WIDTH/8-1:0]   wbm_sel_o,
  output logic                        wbm_stb_o,
  output logic                        wbm_cyc_o,
  input  logic                        wbm_ack_i,
  input  logic                        wbm_err_i
);

  localparam int RATIO = WIDE_WIDTH / NARROW_WIDTH;
  localparam int WSEL  = WIDE_WIDTH / 8;
  localparam int NSEL  = NARROW_WIDTH / 8;
  localparam int BW    = wb_idx_width(RATIO);
  localparam int NOFF  = wb_off_width(NSEL);

  generate
    if (GRANULARITY != WB_GRANULARITY) begin : g_bad_granularity
      $fatal(1, "wb_downsizer: GRANULARITY must be 8");
    end
    if ((NARROW_WIDTH > WIDE_WIDTH) || (RATIO * NARROW_WIDTH != WIDE_WIDTH)) begin : g_bad_width
      $fatal(1, "wb_downsizer: WIDE_WIDTH must be a power-of-two multiple of NARROW_WIDTH");
    end
  endgenerate

  wb_bridge_state_e        state;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [WIDE_WIDTH-1:0]   dat_q;
  logic [WIDE_WIDTH-1:0]   rd_q;
  logic                    we_q;
  logic [WSEL-1:0]         sel_q;
  logic [BW-1:0]           beat;

  logic [WSEL-1:0]         seek_sel;
  logic [BW:0]             seek_start;
  logic [BW-1:0]           seek_beat;
  logic                    seek_found;
  logic [WIDE_WIDTH-1:0]   rd_next;
  logic [WIDE_WIDTH-1:0]   sel_mask;

  // One seeker serves both the first-beat search (live request) and the
  // next-beat search (latched selects, strictly above the current beat).
  always_comb begin
    if (state == IDLE) begin
      seek_sel   = wbs_sel_i;
      seek_start = '0;
    end else begin
      seek_sel   = sel_q;
      seek_start = {1'b0, beat} + 1'b1;
    end
  end

  wb_lane_seek #(
    .WSEL  (WSEL),
    .NSEL  (NSEL),
    .RATIO (RATIO),
    .BW    (BW)
  ) u_seek (
    .sel   (seek_sel),
    .start (seek_start),
    .beat  (seek_beat),
    .found (seek_found)
  );

  always_comb begin
    rd_next = rd_q;
    rd_next[int'(beat)*NARROW_WIDTH +: NARROW_WIDTH] = wbm_dat_i;
    for (int i = 0; i < WSEL; i++) begin
      sel_mask[i*8 +: 8] = {8{sel_q[i]}};
    end
  end

  function automatic logic [ADDR_WIDTH-1:0] lane_adr(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [BW-1:0] b);
    return (a & ~ADDR_WIDTH'(WSEL - 1)) | (ADDR_WIDTH'(b) << NOFF);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      beat      <= '0;
      wbs_dat_o <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_stb_o <= 1'b0;
      wbm_cyc_o <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            adr_q <= wbs_adr_i;
            dat_q <= wbs_dat_i;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            rd_q  <= '0;
            if (seek_found) begin
              beat      <= seek_beat;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= wbs_we_i;
              wbm_adr_o <= lane_adr(wbs_adr_i, seek_beat);
              wbm_sel_o <= wbs_sel_i[int'(seek_beat)*NSEL +: NSEL];
              wbm_dat_o <= wbs_dat_i[int'(seek_beat)*NARROW_WIDTH +: NARROW_WIDTH];
              state     <= BEAT;
            end else begin
              // Empty select: acknowledge without touching the narrow bus.
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= '0;
              state     <= RESP;
            end
          end
        end
        BEAT: begin
          if (!wbs_cyc_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= IDLE;
          end else if (wbm_err_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbs_err_o <= 1'b1;
            wbs_dat_o <= rd_q & sel_mask;
            state     <= RESP;
          end else if (wbm_ack_i) begin
            rd_q <= rd_next;
            if (seek_found) begin
              beat      <= seek_beat;
              wbm_adr_o <= lane_adr(adr_q, seek_beat);
              wbm_sel_o <= sel_q[int'(seek_beat)*NSEL +: NSEL];
              wbm_dat_o <= dat_q[int'(seek_beat)*NARROW_WIDTH +: NARROW_WIDTH];
              wbm_we_o  <= we_q;
            end else begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= rd_next & sel_mask;
              state     <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_downsizer.sv
// Scoreboard bench: a 32->8 bridge against a wait/error-injecting byte slave,
// plus a 64->16 bridge for sparse-select lane placement.
module tb_wb_downsizer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_adr = '0, a_wdat = '0, a_rdat;
  logic        a_we = 1'b0, a_stb = 1'b0, a_cyc = 1'b0, a_ack, a_err;
  logic [3:0]  a_sel = '0;
  logic [31:0] a_madr;
  logic [7:0]  a_mdo, a_mdi;
  logic        a_mwe, a_mstb, a_mcyc, a_mack, a_merr;
  logic [0:0]  a_msel;

  logic [31:0] b_adr = '0, b_madr;
  logic [63:0] b_wdat = '0, b_rdat;
  logic        b_we = 1'b0, b_stb = 1'b0, b_cyc = 1'b0, b_ack, b_err;
  logic [7:0]  b_sel = '0;
  logic [15:0] b_mdo, b_mdi;
  logic        b_mwe, b_mstb, b_mcyc, b_mack, b_merr;
  logic [1:0]  b_msel;

  wb_downsizer #(.ADDR_WIDTH(32), .WIDE_WIDTH(32), .NARROW_WIDTH(8), .GRANULARITY(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .wbs_adr_i(a_adr), .wbs_dat_i(a_wdat), .wbs_dat_o(a_rdat), .wbs_we_i(a_we),
    .wbs_sel_i(a_sel), .wbs_stb_i(a_stb), .wbs_cyc_i(a_cyc), .wbs_ack_o(a_ack), .wbs_err_o(a_err),
    .wbm_adr_o(a_madr), .wbm_dat_o(a_mdo), .wbm_dat_i(a_mdi), .wbm_we_o(a_mwe),
    .wbm_sel_o(a_msel), .wbm_stb_o(a_mstb), .wbm_cyc_o(a_mcyc), .wbm_ack_i(a_mack), .wbm_err_i(a_merr)
  );

  wb_downsizer #(.ADDR_WIDTH(32), .WIDE_WIDTH(64), .NARROW_WIDTH(16), .GRANULARITY(8)) u_dut64 (
    .clk_i(clk), .rst_i(rst),
    .wbs_adr_i(b_adr), .wbs_dat_i(b_wdat), .wbs_dat_o(b_rdat), .wbs_we_i(b_we),
    .wbs_sel_i(b_sel), .wbs_stb_i(b_stb), .wbs_cyc_i(b_cyc), .wbs_ack_o(b_ack), .wbs_err_o(b_err),
    .wbm_adr_o(b_madr), .wbm_dat_o(b_mdo), .wbm_dat_i(b_mdi), .wbm_we_o(b_mwe),
    .wbm_sel_o(b_msel), .wbm_stb_o(b_mstb), .wbm_cyc_o(b_mcyc), .wbm_ack_i(b_mack), .wbm_err_i(b_merr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte slave for the 32->8 bridge: ws wait states per beat, err on beat err_at.
  logic [7:0] mem [0:1023];
  int  ws = 0, err_at = -1, wcnt = 0, bcnt = 0;
  logic a_act;

  function automatic logic [7:0] init_byte(input int i);
    if (i >= 256 && i < 260) return 8'(8'h11 * (i - 255));
    return 8'(i) ^ 8'h5A;
  endfunction

  assign a_act  = a_mcyc && a_mstb && (wcnt >= ws);
  assign a_mack = a_act && (bcnt != err_at);
  assign a_merr = a_act && (bcnt == err_at);
  assign a_mdi  = mem[a_madr[9:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
      wcnt <= 0;
      bcnt <= 0;
    end else if (!a_mcyc) begin
      wcnt <= 0;
      bcnt <= 0;
    end else if (a_mstb) begin
      if (a_act) begin
        wcnt <= 0;
        bcnt <= bcnt + 1;
        if (a_mwe && a_mack) mem[a_madr[9:0]] <= a_mdo;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  assign b_mack = b_mstb && b_mcyc;
  assign b_merr = 1'b0;
  assign b_mdi  = {4'hB, b_madr[11:0]};

  typedef struct { logic [31:0] adr; logic [7:0] dat; logic we; } beat_t;
  typedef struct { logic err; logic chk_dat; logic [31:0] dat; } resp_t;
  typedef struct { logic [31:0] adr; logic [15:0] dat; } bbeat_t;
  beat_t  exp_beat[$];
  resp_t  exp_resp[$];
  bbeat_t exp_bbeat[$];

  always @(negedge clk) begin
    beat_t e;
    if (!rst && a_mcyc && a_mstb && (a_mack || a_merr)) begin
      if (exp_beat.size() == 0) chk("unexpected_beat", a_madr, 32'hFFFF_FFFF);
      else begin
        e = exp_beat.pop_front();
        chk("beat_adr", a_madr, e.adr);
        chk("beat_we", a_mwe, e.we);
        chk("beat_sel", a_msel, 1'b1);
        if (e.we) chk("beat_wdat", a_mdo, e.dat);
      end
    end
  end

  always @(negedge clk) begin
    resp_t r;
    if (!rst && (a_ack || a_err)) begin
      chk("ack_err_excl", a_ack && a_err, 1'b0);
      if (exp_resp.size() == 0) chk("unexpected_resp", {a_ack, a_err}, 2'b00);
      else begin
        r = exp_resp.pop_front();
        chk("resp_err", a_err, r.err);
        if (r.chk_dat) chk("resp_dat", a_rdat, r.dat);
      end
    end
  end

  always @(negedge clk) begin
    bbeat_t e;
    if (!rst && b_mcyc && b_mstb && b_mack) begin
      if (exp_bbeat.size() == 0) chk("b_unexpected_beat", b_madr, 32'hFFFF_FFFF);
      else begin
        e = exp_bbeat.pop_front();
        chk("b_beat_adr", b_madr, e.adr);
        chk("b_beat_dat", b_mdo, e.dat);
        chk("b_beat_sel", b_msel, 2'b11);
        chk("b_beat_we", b_mwe, 1'b0);
      end
    end
  end

  // Model of one 32->8 transaction; limit < 0 means every selected beat completes.
  task automatic expect_txn(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                            input logic [3:0] sel, input int limit, input logic err, input logic resp);
    beat_t b;
    resp_t r;
    int n;
    logic [31:0] base;
    n = 0;
    base = {adr[31:2], 2'b00};
    r.dat = '0;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) begin
        if (limit < 0 || n < limit) begin
          b.adr = base + 32'(k);
          b.dat = dat[k*8 +: 8];
          b.we  = we;
          exp_beat.push_back(b);
        end
        r.dat[k*8 +: 8] = mem[int'(base[9:0]) + k];
        n++;
      end
    end
    r.err = err;
    r.chk_dat = !we && !err;
    if (resp) exp_resp.push_back(r);
  endtask

  task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input logic [3:0] sel, output int lat, output logic saw_cyc);
    lat = -1;
    saw_cyc = 1'b0;
    @(posedge clk); #1;
    a_adr = adr; a_wdat = dat; a_we = we; a_sel = sel; a_cyc = 1'b1; a_stb = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (a_mcyc) saw_cyc = 1'b1;
      if (a_ack || a_err) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk("txn_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
    @(negedge clk);
    chk("resp_one_cycle", {a_ack, a_err}, 2'b00);
  endtask

  task automatic do_txn(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                        input logic [3:0] sel, output int lat);
    logic saw;
    expect_txn(adr, dat, we, sel, -1, 1'b0, 1'b1);
    run_txn(adr, dat, we, sel, lat, saw);
  endtask

  initial begin
    int lat;
    logic saw;
    logic [31:0] r_adr;
    logic [3:0]  r_sel;
    logic        r_we;
    bit          got;

    #1 rst = 1'b1;
    #1;
    chk("rst_a_outputs", {a_ack, a_err, a_rdat, a_madr, a_mdo, a_mwe, a_msel, a_mstb, a_mcyc}, '0);
    chk("rst_b_outputs", {b_ack, b_err, b_rdat, b_madr, b_mdo, b_mwe, b_msel, b_mstb, b_mcyc}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full-word read through byte lanes, zero-wait.
    do_txn(32'h100, 32'h0, 1'b0, 4'hF, lat);
    chk("t1_latency", lat, 5);
    chk("t1_rdat", a_rdat, 32'h4433_2211);

    // Sparse write: two beats only.
    do_txn(32'h204, 32'hAABB_CCDD, 1'b1, 4'b0101, lat);
    chk("t2_latency", lat, 3);
    do_txn(32'h204, 32'h0, 1'b0, 4'hF, lat);
    chk("t2_readback_b2", a_rdat[23:16], 8'hBB);
    chk("t2_readback_b0", a_rdat[7:0], 8'hDD);

    // Empty select: immediate ack, narrow bus untouched.
    expect_txn(32'h80, 32'h0, 1'b0, 4'h0, -1, 1'b0, 1'b1);
    run_txn(32'h80, 32'h0, 1'b0, 4'h0, lat, saw);
    chk("t5_latency", lat, 1);
    chk("t5_no_cyc", saw, 1'b0);

    // Slave error on beat 1 aborts the rest, then a clean transfer follows.
    err_at = 1;
    expect_txn(32'h100, 32'h0, 1'b0, 4'hF, 2, 1'b1, 1'b1);
    run_txn(32'h100, 32'h0, 1'b0, 4'hF, lat, saw);
    chk("t4_err_latency", lat, 3);
    err_at = -1;
    do_txn(32'h100, 32'h0, 1'b0, 4'hF, lat);
    chk("t4_after_err_rdat", a_rdat, 32'h4433_2211);

    // Randomised mix with wait states.
    for (int i = 0; i < 8; i++) begin
      ws    = $urandom_range(0, 2);
      r_adr = 32'($urandom_range(0, 255)) << 2;
      r_sel = 4'($urandom_range(1, 15));
      r_we  = 1'($urandom_range(0, 1));
      do_txn(r_adr, $urandom, r_we, r_sel, lat);
    end
    ws = 0;

    // Upstream abort while beat 2 is wait-stated.
    ws = 3;
    expect_txn(32'h140, 32'h0, 1'b0, 4'hF, 2, 1'b0, 1'b0);
    @(posedge clk); #1;
    a_adr = 32'h140; a_sel = 4'hF; a_we = 1'b0; a_cyc = 1'b1; a_stb = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (a_mstb && a_madr == 32'h142) got = 1'b1;
    end
    chk("t6_reach_beat2", got, 1'b1);
    @(posedge clk); #1;
    a_cyc = 1'b0; a_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_abort_cyc_stb", {a_mcyc, a_mstb}, 2'b00);
    repeat (4) @(negedge clk);
    chk("t6_abort_beats_left", exp_beat.size(), 0);

    // Asynchronous reset in the middle of a beat.
    @(posedge clk); #1;
    a_adr = 32'h180; a_wdat = 32'h1234_5678; a_sel = 4'hF; a_we = 1'b1; a_cyc = 1'b1; a_stb = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (a_mstb) got = 1'b1;
    end
    chk("t6_rst_reach_beat", got, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_async_outputs", {a_ack, a_err, a_rdat, a_madr, a_mdo, a_mwe, a_msel, a_mstb, a_mcyc}, '0);
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ws = 0;
    do_txn(32'h180, 32'h0, 1'b0, 4'b0110, lat);
    chk("t6_post_rst_latency", lat, 3);

    // 64->16: upper-half select only.
    exp_bbeat.push_back('{adr: 32'h304, dat: 16'h3344});
    exp_bbeat.push_back('{adr: 32'h306, dat: 16'h1122});
    @(posedge clk); #1;
    b_adr = 32'h300; b_wdat = 64'h1122_3344_5566_7788; b_sel = 8'hF0; b_we = 1'b0;
    b_cyc = 1'b1; b_stb = 1'b1;
    lat = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (b_ack || b_err) begin
        lat = c;
        break;
      end
    end
    chk("t3_latency", lat, 3);
    chk("t3_err", b_err, 1'b0);
    chk("t3_rdat", b_rdat, 64'hB306_B304_0000_0000);
    @(posedge clk); #1;
    b_cyc = 1'b0; b_stb = 1'b0;
    repeat (3) @(negedge clk);

    chk("beats_left", exp_beat.size(), 0);
    chk("resps_left", exp_resp.size(), 0);
    chk("b_beats_left", exp_bbeat.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
